// File: rtl/fp_align_pkg.sv
// Shared constants, FSM encoding and lane helper for the PE alignment blocks.
package fp_align_pkg;

  localparam int unsigned EXP_W  = 11;
  localparam int unsigned LANES  = 4;
  localparam int unsigned GROUPS = 4;
  localparam int unsigned NUM_IN = LANES * GROUPS;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StScan  = 2'd1,
    StAlign = 2'd2
  } align_state_e;

  // Extract exponent idx from a flat NUM_IN-wide exponent bus.
  function automatic logic [EXP_W-1:0] lane_slice(input logic [NUM_IN*EXP_W-1:0] vec,
                                                  input int unsigned idx);
    return vec[idx*EXP_W +: EXP_W];
  endfunction

endpackage

// File: rtl/max4_select.sv
// Combinational max over four exponents, honouring a per-lane valid mask.
module max4_select
  import fp_align_pkg::*;
(
  input  logic [LANES-1:0][EXP_W-1:0] exps,
  input  logic [LANES-1:0]            mask,
  output logic [EXP_W-1:0]            max_exp,
  output logic                        any_valid
);

  // Linear scan; only masked-in lanes can raise the running max.
  always_comb begin
    max_exp   = '0;
    any_valid = 1'b0;
    for (int j = 0; j < int'(LANES); j++) begin
      if (mask[j] && (!any_valid || exps[j] > max_exp)) begin
        max_exp   = exps[j];
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/exp_align_scheduler.sv
// Time-multiplexed exponent alignment: scan 16 exponents 4 at a time for the
// global max, then emit per-lane right-shift amounts one 4-lane group at a time.
module exp_align_scheduler
  import fp_align_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_IN*EXP_W-1:0]   in_exp,
  input  logic [NUM_IN-1:0]         in_zero,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [1:0]                out_group,
  output logic [LANES*EXP_W-1:0]    out_shift,
  output logic [EXP_W-1:0]          out_exp_max,
  output logic                      out_last
);

  align_state_e              state_q, state_d;
  logic [1:0]                grp_q, grp_d;
  logic [NUM_IN*EXP_W-1:0]   exp_q, exp_d;
  logic [NUM_IN-1:0]         zero_q, zero_d;
  logic [EXP_W-1:0]          run_max_q, run_max_d;
  logic                      any_nz_q, any_nz_d;

  logic [LANES-1:0][EXP_W-1:0] grp_exp;
  logic [LANES-1:0]            grp_zero;
  logic [LANES-1:0]            grp_mask;
  logic [EXP_W-1:0]            grp_max;
  logic                        grp_any;
  logic                        grp_is_last;

  assign grp_is_last = (grp_q == 2'(GROUPS - 1));

  // Route the current group's registered exponents and zero flags to the lanes.
  always_comb begin
    for (int j = 0; j < int'(LANES); j++) begin
      grp_exp[j]  = lane_slice(exp_q, 32'({grp_q, 2'(j)}));
      grp_zero[j] = zero_q[{grp_q, 2'(j)}];
    end
    grp_mask = ~grp_zero;
  end

  max4_select u_max4_select (
    .exps      (grp_exp),
    .mask      (grp_mask),
    .max_exp   (grp_max),
    .any_valid (grp_any)
  );

  // Next-state: accept in IDLE, accumulate max in SCAN, step groups on ALIGN handshakes.
  always_comb begin
    state_d   = state_q;
    grp_d     = grp_q;
    exp_d     = exp_q;
    zero_d    = zero_q;
    run_max_d = run_max_q;
    any_nz_d  = any_nz_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          exp_d     = in_exp;
          zero_d    = in_zero;
          run_max_d = '0;
          any_nz_d  = 1'b0;
          grp_d     = '0;
          state_d   = StScan;
        end
      end
      StScan: begin
        if (grp_any) begin
          run_max_d = (any_nz_q && run_max_q > grp_max) ? run_max_q : grp_max;
          any_nz_d  = 1'b1;
        end
        grp_d = grp_q + 2'd1;
        if (grp_is_last) begin
          grp_d   = '0;
          state_d = StAlign;
        end
      end
      StAlign: begin
        if (out_ready) begin
          grp_d = grp_q + 2'd1;
          if (grp_is_last) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset; an in-flight set is simply dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      grp_q     <= '0;
      exp_q     <= '0;
      zero_q    <= '0;
      run_max_q <= '0;
      any_nz_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grp_q     <= grp_d;
      exp_q     <= exp_d;
      zero_q    <= zero_d;
      run_max_q <= run_max_d;
      any_nz_q  <= any_nz_d;
    end
  end

  // Outputs decoded from registered state only; run_max dominates every
  // unmasked exponent, so the subtraction never underflows.
  always_comb begin
    in_ready    = (state_q == StIdle);
    out_valid   = (state_q == StAlign);
    out_group   = out_valid ? grp_q : 2'd0;
    out_last    = out_valid && grp_is_last;
    out_exp_max = out_valid ? run_max_q : '0;
    out_shift   = '0;
    for (int j = 0; j < int'(LANES); j++) begin
      if (out_valid && !grp_zero[j]) begin
        out_shift[j*EXP_W +: EXP_W] = run_max_q - grp_exp[j];
      end
    end
  end

endmodule

// File: tb/tb_exp_align_scheduler.sv
module tb_exp_align_scheduler;
  import fp_align_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    in_valid;
  logic                    in_ready;
  logic [NUM_IN*EXP_W-1:0] in_exp;
  logic [NUM_IN-1:0]       in_zero;
  logic                    out_valid;
  logic                    out_ready;
  logic [1:0]              out_group;
  logic [LANES*EXP_W-1:0]  out_shift;
  logic [EXP_W-1:0]        out_exp_max;
  logic                    out_last;

  int n_checks = 0;
  int n_fail   = 0;

  exp_align_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_exp      (in_exp),
    .in_zero     (in_zero),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_group   (out_group),
    .out_shift   (out_shift),
    .out_exp_max (out_exp_max),
    .out_last    (out_last)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_out_shift"}, 64'(out_shift), 64'd0);
    check({tag, "_out_exp_max"}, 64'(out_exp_max), 64'd0);
    check({tag, "_out_last"}, 64'(out_last), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("reset");
  endtask

  // Offers one set, checks latency, then every group against the model.
  task automatic run_set(input logic [NUM_IN*EXP_W-1:0] e, input logic [NUM_IN-1:0] z,
                         input int stall_grp, input int stall_len, input bit hold_valid);
    int emax;
    bit any;
    int ek;
    int sh[NUM_IN];
    int cnt;
    logic [LANES*EXP_W-1:0] exp_vec;
    emax = 0;
    any  = 1'b0;
    for (int k = 0; k < int'(NUM_IN); k++) begin
      ek = int'(e[k*EXP_W +: EXP_W]);
      if (!z[k] && (!any || ek > emax)) begin
        emax = ek;
        any  = 1'b1;
      end
    end
    for (int k = 0; k < int'(NUM_IN); k++) begin
      ek    = int'(e[k*EXP_W +: EXP_W]);
      sh[k] = z[k] ? 0 : emax - ek;
    end

    in_exp   = e;
    in_zero  = z;
    in_valid = 1'b1;
    cnt = 0;
    while (!in_ready && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check("accept_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    if (!hold_valid) in_valid = 1'b0;
    check("busy_ready", 64'(in_ready), 64'd0);
    repeat (3) @(negedge clk);
    check("latency_edge4", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("latency_edge5", 64'(out_valid), 64'd1);

    for (int g = 0; g < int'(GROUPS); g++) begin
      for (int j = 0; j < int'(LANES); j++) exp_vec[j*EXP_W +: EXP_W] = EXP_W'(sh[g*4+j]);
      if (g == stall_grp) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          check("stall_group", 64'(out_group), 64'(g));
          check("stall_shift", 64'(out_shift), 64'(exp_vec));
          check("stall_ready", 64'(in_ready), 64'd0);
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
      check("grp_valid", 64'(out_valid), 64'd1);
      check("grp_index", 64'(out_group), 64'(g));
      check("grp_shift", 64'(out_shift), 64'(exp_vec));
      check("grp_max", 64'(out_exp_max), 64'(emax));
      check("grp_last", 64'(out_last), 64'(g == int'(GROUPS) - 1));
      @(negedge clk);
    end
    check("done_ready", 64'(in_ready), 64'd1);
    check("done_valid", 64'(out_valid), 64'd0);
  endtask

  initial begin
    logic [NUM_IN*EXP_W-1:0] e;
    logic [NUM_IN-1:0]       z;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_exp    = '0;
    in_zero   = '0;
    out_ready = 1'b1;
    do_reset();

    // Basic ramp: max 115, group0 shifts 15..12, group3 3..0.
    for (int k = 0; k < 16; k++) e[k*EXP_W +: EXP_W] = EXP_W'(100 + k);
    run_set(e, 16'h0000, 4, 0, 1'b0);

    // Masking: only input 9 (1023) survives.
    for (int k = 0; k < 16; k++) e[k*EXP_W +: EXP_W] = EXP_W'(2000);
    e[9*EXP_W +: EXP_W] = EXP_W'(1023);
    run_set(e, 16'hFDFF, 4, 0, 1'b0);
    run_set(e, 16'hFFFF, 4, 0, 1'b0);

    // Backpressure on group 1 for 3 cycles.
    for (int k = 0; k < 16; k++) e[k*EXP_W +: EXP_W] = EXP_W'(100 + k);
    run_set(e, 16'h0000, 1, 3, 1'b0);

    // Reset during the second scan cycle.
    in_exp = e; in_zero = '0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midscan_ready", 64'(in_ready), 64'd1);
    check("midscan_valid", 64'(out_valid), 64'd0);
    for (int k = 0; k < 16; k++) e[k*EXP_W +: EXP_W] = EXP_W'(400);
    e[0 +: EXP_W] = EXP_W'(500);
    run_set(e, 16'h0000, 4, 0, 1'b0);

    // Reset while a group is stalled in ALIGN.
    in_exp = e; in_valid = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (5) @(negedge clk);
    check("midalign_valid", 64'(out_valid), 64'd1);
    do_reset();
    out_ready = 1'b1;

    // Back-to-back with in_valid held; second set has a lower max.
    for (int k = 0; k < 16; k++) e[k*EXP_W +: EXP_W] = EXP_W'(1500 + 3 * k);
    run_set(e, 16'h0000, 2, 2, 1'b1);
    for (int k = 0; k < 16; k++) e[k*EXP_W +: EXP_W] = EXP_W'(40 + (k % 5));
    run_set(e, 16'h0010, 4, 0, 1'b0);

    // Randomized sets.
    for (int r = 0; r < 12; r++) begin
      for (int k = 0; k < 16; k++) e[k*EXP_W +: EXP_W] = EXP_W'($urandom_range(0, 2047));
      case (r % 3)
        0:       z = '0;
        1:       z = 16'($urandom);
        default: z = 16'($urandom) | 16'($urandom) | 16'($urandom);
      endcase
      run_set(e, z, int'($urandom_range(0, 4)), int'($urandom_range(1, 3)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
